packet_arb_wrr_n_to_1: RTL and testbench

PACKET_ARB_WRR_N_TO_1 -- requirements
Module: packet_arb_wrr_n_to_1

---
 rtl/packet_arb_wrr_n_to_1_if.sv | 23 ++
 rtl/packet_arb_wrr_n_to_1.sv | 184 ++++++++++++++++++
 tb/tb_packet_arb_wrr_n_to_1.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_arb_wrr_n_to_1_if.sv
// Packet stream bundle: data beat plus framing/control, valid/ready handshake.
// source drives the beat and samples rdy; sink does the opposite.
interface if_axi_stream #(
  parameter int DAT_BYTS = 8,
  parameter int CTL_BITS = 8
);
  localparam int DAT_BITS = DAT_BYTS * 8;
  localparam int MOD_BITS = (DAT_BYTS == 1) ? 1 : $clog2(DAT_BYTS);

  logic [DAT_BITS-1:0] dat;
  logic                val;
  logic                sop;
  logic                eop;
  logic                err;
  logic [MOD_BITS-1:0] mod;
  logic [CTL_BITS-1:0] ctl;
  logic                rdy;

  modport source (output dat, val, sop, eop, err, mod, ctl, input rdy);
  modport sink   (input dat, val, sop, eop, err, mod, ctl, output rdy);
  modport master (output dat, val, sop, eop, err, mod, ctl, input rdy);
  modport slave  (input dat, val, sop, eop, err, mod, ctl, output rdy);
endinterface

// File: rtl/packet_arb_wrr_n_to_1.sv
// Weighted round-robin N:1 packet arbiter, no interleaving; PACKET_ARB_WRR_STATS_EN adds o_pkt_cnt.
// Latency: one cycle from input beat acceptance to o_axi.val (registered output stage).
// Backpressure: only the granted input sees rdy, and only when the output register can take a beat.
module packet_arb_wrr_n_to_1 #(
  parameter int DAT_BYTS    = 8,
  parameter int DAT_BITS    = DAT_BYTS * 8,
  parameter int CTL_BITS    = 8,
  parameter int NUM_IN      = 4,
  parameter int LOG2_NUM_IN = (NUM_IN == 1) ? 1 : $clog2(NUM_IN),
  parameter int OVR_WRT_BIT = CTL_BITS - LOG2_NUM_IN,
  parameter int WGT_BITS    = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  if_axi_stream.sink                   i_axi [NUM_IN-1:0],
  input  logic [NUM_IN*WGT_BITS-1:0]   i_weight,
  if_axi_stream.source                 o_axi
`ifdef PACKET_ARB_WRR_STATS_EN
  ,
  output logic [NUM_IN*32-1:0]         o_pkt_cnt
`endif
);

  localparam int MOD_BITS = (DAT_BYTS == 1) ? 1 : $clog2(DAT_BYTS);
  localparam logic [LOG2_NUM_IN:0]   NUM_IN_W = (LOG2_NUM_IN+1)'(NUM_IN);
  localparam logic [LOG2_NUM_IN-1:0] LAST_ID  = LOG2_NUM_IN'(NUM_IN - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t state, state_nxt;

  logic [LOG2_NUM_IN-1:0] ptr, ptr_nxt;
  logic [LOG2_NUM_IN-1:0] gnt_q, gnt_nxt, gnt;
  logic [LOG2_NUM_IN-1:0] sel_id;
  logic [LOG2_NUM_IN:0]   cand;
  logic [WGT_BITS-1:0]    credit, credit_nxt, wgt_sel;
  logic                   sel_found;
  logic                   out_adv;
  logic                   take;

  logic [NUM_IN-1:0]   in_val, in_sop, in_eop, in_err, in_rdy;
  logic [DAT_BITS-1:0] in_dat [NUM_IN];
  logic [MOD_BITS-1:0] in_mod [NUM_IN];
  logic [CTL_BITS-1:0] in_ctl [NUM_IN];
  logic [WGT_BITS-1:0] wgt    [NUM_IN];

  logic                out_val, out_sop, out_eop, out_err;
  logic [DAT_BITS-1:0] out_dat;
  logic [MOD_BITS-1:0] out_mod;
  logic [CTL_BITS-1:0] out_ctl;
  logic [CTL_BITS-1:0] ctl_nxt;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    assign in_val[g]    = i_axi[g].val;
    assign in_sop[g]    = i_axi[g].sop;
    assign in_eop[g]    = i_axi[g].eop;
    assign in_err[g]    = i_axi[g].err;
    assign in_dat[g]    = i_axi[g].dat;
    assign in_mod[g]    = i_axi[g].mod;
    assign in_ctl[g]    = i_axi[g].ctl;
    assign wgt[g]       = i_weight[g*WGT_BITS +: WGT_BITS];
    assign i_axi[g].rdy = in_rdy[g];
  end

  // Rotating priority search: first channel at or above ptr offering a start of packet.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      cand = {1'b0, ptr} + (LOG2_NUM_IN+1)'(i);
      if (cand >= NUM_IN_W) cand = cand - NUM_IN_W;
      if (!sel_found && in_val[cand[LOG2_NUM_IN-1:0]] && in_sop[cand[LOG2_NUM_IN-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = cand[LOG2_NUM_IN-1:0];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    credit_nxt = credit;
    gnt_nxt    = gnt_q;
    take       = 1'b0;
    in_rdy     = '0;
    out_adv    = !out_val || o_axi.rdy;
    gnt        = (state == LOCK) ? gnt_q : sel_id;
    wgt_sel    = wgt[sel_id];
    ctl_nxt    = in_ctl[gnt];
    ctl_nxt[OVR_WRT_BIT +: LOG2_NUM_IN] = gnt;

    case (state)
      IDLE: begin
        if (sel_found && out_adv) begin
          take           = 1'b1;
          in_rdy[sel_id] = 1'b1;
          gnt_nxt        = sel_id;
          // A zero weight behaves as one packet per turn.
          if (credit == '0) credit_nxt = (wgt_sel == '0) ? '0 : wgt_sel - 1'b1;
          else              credit_nxt = credit - 1'b1;
          if (credit_nxt == '0) ptr_nxt = (sel_id == LAST_ID) ? '0 : sel_id + 1'b1;
          else                  ptr_nxt = sel_id;
          if (!in_eop[sel_id]) state_nxt = LOCK;
        end
      end
      LOCK: begin
        if (out_adv) begin
          in_rdy[gnt_q] = 1'b1;
          take          = in_val[gnt_q];
          if (take && in_eop[gnt_q]) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (i_rst) in_rdy = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      ptr    <= '0;
      credit <= '0;
      gnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      credit <= credit_nxt;
      gnt_q  <= gnt_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_val <= 1'b0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      out_err <= 1'b0;
      out_dat <= '0;
      out_mod <= '0;
      out_ctl <= '0;
    end else if (out_adv) begin
      out_val <= take;
      if (take) begin
        out_sop <= in_sop[gnt];
        out_eop <= in_eop[gnt];
        out_err <= in_err[gnt];
        out_dat <= in_dat[gnt];
        out_mod <= in_mod[gnt];
        out_ctl <= ctl_nxt;
      end
    end
  end

  assign o_axi.val = out_val;
  assign o_axi.sop = out_sop;
  assign o_axi.eop = out_eop;
  assign o_axi.err = out_err;
  assign o_axi.dat = out_dat;
  assign o_axi.mod = out_mod;
  assign o_axi.ctl = out_ctl;

`ifdef PACKET_ARB_WRR_STATS_EN
  // The channel id travels with the beat in ctl, so counting needs no extra tracking.
  logic [31:0]            pkt_cnt [NUM_IN];
  logic [LOG2_NUM_IN-1:0] out_id;

  assign out_id = out_ctl[OVR_WRT_BIT +: LOG2_NUM_IN];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_IN; k++) pkt_cnt[k] <= '0;
    end else if (out_val && o_axi.rdy && out_eop) begin
      pkt_cnt[out_id] <= pkt_cnt[out_id] + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_cnt
    assign o_pkt_cnt[g*32 +: 32] = pkt_cnt[g];
  end
`endif

endmodule

// File: tb/tb_packet_arb_wrr_n_to_1.sv
// Bench for the WRR packet arbiter: queue-driven sources, scoreboard model of grant order,
// per-cycle output/rdy checks and a few hand-derived channel-order sequences.
`timescale 1ns/1ps
module tb_packet_arb_wrr_n_to_1;
  localparam int N    = 4;
  localparam int DB   = 8;
  localparam int DW   = DB * 8;
  localparam int CB   = 8;
  localparam int LOG2 = 2;
  localparam int OVR  = CB - LOG2;
  localparam int MB   = 3;
  localparam int WB   = 4;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          sop;
    logic          eop;
    logic          err;
    logic [MB-1:0] mod;
    logic [CB-1:0] ctl;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic o_rdy = 1'b1;
  logic [N*WB-1:0] weight = {N{4'd1}};
  logic [N-1:0] rdy_w;
  logic [N-1:0] drv_val = '0;
  beat_t drv [N];

  beat_t src_q [N][$];
  beat_t exp_q [N][$];
  logic  ordy_q [$];
  int    out_ch_q [$];
  int    out_cyc_q [$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  int m_ptr = 0;
  int m_credit = 0;
  int m_cur = 0;
  bit m_lock = 1'b0;

  always #5 clk = ~clk;

  if_axi_stream #(.DAT_BYTS(DB), .CTL_BITS(CB)) in_if [N-1:0] ();
  if_axi_stream #(.DAT_BYTS(DB), .CTL_BITS(CB)) out_if ();

`ifdef PACKET_ARB_WRR_STATS_EN
  logic [N*32-1:0] pkt_cnt;
`endif

  packet_arb_wrr_n_to_1 #(
    .DAT_BYTS(DB), .CTL_BITS(CB), .NUM_IN(N), .WGT_BITS(WB)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_axi    (in_if),
    .i_weight (weight),
    .o_axi    (out_if)
`ifdef PACKET_ARB_WRR_STATS_EN
    ,
    .o_pkt_cnt(pkt_cnt)
`endif
  );

  for (genvar g = 0; g < N; g++) begin : g_src
    assign in_if[g].dat = drv[g].dat;
    assign in_if[g].val = drv_val[g];
    assign in_if[g].sop = drv[g].sop;
    assign in_if[g].eop = drv[g].eop;
    assign in_if[g].err = drv[g].err;
    assign in_if[g].mod = drv[g].mod;
    assign in_if[g].ctl = drv[g].ctl;
    assign rdy_w[g]     = in_if[g].rdy;
  end
  assign out_if.rdy = o_rdy;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int first_elig(logic [N-1:0] e, int p);
    for (int i = 0; i < N; i++) begin
      if (e[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic push_pkt(int ch, int len, int pid);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.dat = {8'(ch), 8'(pid), 8'(i), 40'h5A_C3_0F_96_11};
      b.sop = (i == 0);
      b.eop = (i == len - 1);
      b.err = (i == len - 1) && pid[0];
      b.mod = MB'(i + pid);
      b.ctl = CB'(pid * 37 + i * 5 + 3);
      src_q[ch].push_back(b);
      b.ctl[OVR +: LOG2] = LOG2'(ch);
      exp_q[ch].push_back(b);
    end
  endtask

  // Scoreboard step for one newly registered output beat.
  task automatic model_beat(beat_t ob, logic [N-1:0] elig);
    int ch, w;
    beat_t eb;
    if (m_lock) begin
      ch = m_cur;
    end else begin
      ch = first_elig(elig, m_ptr);
      chk("grant_source", ch >= 0, 1);
      if (ch < 0) return;
      w = int'(weight[ch*WB +: WB]);
      if (w == 0) w = 1;
      if (m_credit == 0) m_credit = w - 1;
      else m_credit = m_credit - 1;
      m_ptr = (m_credit == 0) ? (ch + 1) % N : ch;
    end
    chk("out_chan", ob.ctl[OVR +: LOG2], ch);
    out_ch_q.push_back(int'(ob.ctl[OVR +: LOG2]));
    out_cyc_q.push_back(cyc);
    if (exp_q[ch].size() == 0) begin
      chk("beat_expected", 0, 1);
      m_lock = 1'b0;
    end else begin
      eb = exp_q[ch].pop_front();
      chk("out_beat", ob, eb);
      m_lock = !eb.eop;
      m_cur  = ch;
    end
  endtask

  // Source driver: sample handshake mid-cycle, advance queues just after the edge.
  initial begin : driver
    logic [N-1:0] hs;
    for (int k = 0; k < N; k++) drv[k] = '0;
    forever begin
      @(negedge clk);
      hs = drv_val & rdy_w;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0) begin
          drv[k]     = src_q[k][0];
          drv_val[k] = 1'b1;
        end else begin
          drv[k]     = '0;
          drv_val[k] = 1'b0;
        end
      end
      if (ordy_q.size() > 0) o_rdy = ordy_q.pop_front();
      else o_rdy = 1'b1;
    end
  end

  initial begin : compare
    beat_t ob, pb;
    logic [N-1:0] rdy_s, hs_s, el_s, p_hs, p_el, erdy;
    logic ov, pov, pors, rprev;
    int ch;
    pov = 1'b0; pors = 1'b1; rprev = 1'b1;
    p_hs = '0; p_el = '0; pb = '0;
    forever begin
      @(negedge clk);
      cyc++;
      ob.dat = out_if.dat; ob.sop = out_if.sop; ob.eop = out_if.eop;
      ob.err = out_if.err; ob.mod = out_if.mod; ob.ctl = out_if.ctl;
      ov    = out_if.val;
      rdy_s = rdy_w;
      for (int k = 0; k < N; k++) el_s[k] = drv_val[k] && drv[k].sop;
      hs_s = drv_val & rdy_s;
      if (rprev) begin
        chk("rst_o_val", ov, 0);
        chk("rst_o_fields", ob, 0);
        m_lock = 1'b0; m_ptr = 0; m_credit = 0;
        for (int k = 0; k < N; k++) exp_q[k].delete();
      end else if (pov && !pors) begin
        chk("hold_val", ov, 1);
        chk("hold_beat", ob, pb);
      end else begin
        chk("o_val", ov, |p_hs);
        if (ov) model_beat(ob, p_el);
      end
      erdy = '0;
      if (!rst && (!ov || o_rdy)) begin
        if (m_lock) erdy[m_cur] = 1'b1;
        else begin
          ch = first_elig(el_s, m_ptr);
          if (ch >= 0) erdy[ch] = 1'b1;
        end
      end
      chk("in_rdy", rdy_s, erdy);
      pov = ov; pors = o_rdy; rprev = rst;
      p_hs = hs_s; p_el = el_s; pb = ob;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < N; k++) src_q[k].delete();
    ordy_q.delete();
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
    out_ch_q.delete();
    out_cyc_q.delete();
  endtask

  task automatic wait_idle(string nm, int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      done = 1'b1;
      for (int k = 0; k < N; k++)
        if (src_q[k].size() != 0 || exp_q[k].size() != 0) done = 1'b0;
    end
    chk(nm, done, 1);
  endtask

  task automatic wait_beats(string nm, int n, int budget);
    for (int i = 0; i < budget && out_ch_q.size() < n; i++) step();
    chk(nm, out_ch_q.size() >= n, 1);
  endtask

  task automatic check_seq(string nm, input int e[$]);
    chk({nm, "_len"}, out_ch_q.size() >= e.size(), 1);
    for (int i = 0; i < e.size() && i < out_ch_q.size(); i++) chk(nm, out_ch_q[i], e[i]);
  endtask

  initial begin : main
    int e[$];
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // All weights 1, one 3-beat packet per channel: strict rotation, no idle cycles.
    for (int k = 0; k < N; k++) push_pkt(k, 3, k);
    wait_idle("drain_rotation", 200);
    e = '{0,0,0,1,1,1,2,2,2,3,3,3};
    check_seq("seq_rotation", e);
    chk("rotation_beats", out_ch_q.size(), 12);
    if (out_cyc_q.size() == 12) chk("rotation_span", out_cyc_q[11] - out_cyc_q[0], 11);

    // ch0 weight 3, ch1 weight 1, single-beat packets.
    do_reset();
    weight = {4'd1, 4'd1, 4'd1, 4'd3};
    for (int p = 0; p < 8; p++) begin
      push_pkt(0, 1, 16 + p);
      push_pkt(1, 1, 32 + p);
    end
    wait_idle("drain_weighted", 200);
    e = '{0,0,0,1,0,0,0,1};
    check_seq("seq_weighted", e);
    chk("weighted_beats", out_ch_q.size(), 16);

    // ch0 arrives mid-way through a ch2 packet and must wait for its eop.
    do_reset();
    weight = {N{4'd1}};
    push_pkt(2, 5, 50);
    wait_beats("wait_ch2_beat2", 2, 100);
    push_pkt(0, 3, 51);
    wait_idle("drain_no_interleave", 200);
    e = '{2,2,2,2,2,0,0,0};
    check_seq("seq_no_interleave", e);

    // Output stalls mid-packet, then a second channel's packet follows.
    do_reset();
    e = '{1,1,0,0,1,0,0,1,0,1};
    foreach (e[i]) ordy_q.push_back(e[i][0]);
    push_pkt(1, 4, 61);
    push_pkt(3, 2, 62);
    wait_idle("drain_backpressure", 200);
    e = '{1,1,1,1,3,3};
    check_seq("seq_backpressure", e);
    chk("backpressure_beats", out_ch_q.size(), 6);

    // Reset mid-packet; pointer must restart at 0 (stale ptr would favour ch3).
    do_reset();
    weight = {4'd2, 4'd1, 4'd1, 4'd1};
    push_pkt(3, 6, 71);
    wait_beats("wait_ch3_beat3", 3, 100);
    do_reset();
    push_pkt(3, 2, 72);
    push_pkt(1, 3, 73);
    wait_idle("drain_after_reset", 200);
    e = '{1,1,1,3,3};
    check_seq("seq_after_reset", e);

`ifdef PACKET_ARB_WRR_STATS_EN
    do_reset();
    weight = {N{4'd1}};
    for (int p = 0; p < 7; p++) push_pkt(1, 2, 80 + p);
    wait_idle("drain_stats", 300);
    step();
    chk("pkt_cnt_ch0", pkt_cnt[31:0], 0);
    chk("pkt_cnt_ch1", pkt_cnt[63:32], 7);
    chk("pkt_cnt_ch2", pkt_cnt[95:64], 0);
    chk("pkt_cnt_ch3", pkt_cnt[127:96], 0);
`endif

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
